md_sequencer: RTL and testbench

Multi-cycle multiply/divide controller for the EX stage of the five-stage pipeline. It accepts one operation per start pulse, latches the operands, and holds `busy` high for a fixed per-operation latency. At the end of that latency it commits the result to the HI/LO registers. The hazard unit stalls D-stage HI/LO and mult/div instructions on `start | busy`, and the EX stage reads `hi`/`lo` directly for mfhi/mflo.

---
 rtl/md_sequencer.sv | 128 ++++++++++++
 tb/tb_md_sequencer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/md_sequencer.sv
// Multi-cycle multiply/divide sequencer with HI/LO registers for the EX stage.
// Define MD_SEQUENCER_MADD_EN to enable madd/maddu (ops 6/7) accumulating into {hi,lo}.
module md_sequencer #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [3:0] MULT_LAT = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_LAT  = 4'(DIV_CYCLES);

  state_t      state;
  logic [3:0]  cnt;
  logic [2:0]  op_q;
  logic [31:0] a_q, b_q;

  logic        accept;
  logic [3:0]  lat;
  logic signed [63:0] a_s, b_s, prod_s;
  logic [63:0] prod_u;
  logic [31:0] sq, sr, uq, ur;
  logic        commit_en;
  logic [31:0] res_hi, res_lo;

  // Decode of a start request into "goes to RUN" plus its latency.
  always_comb begin
    accept = 1'b0;
    lat    = MULT_LAT;
    case (op)
      3'd0, 3'd1: begin accept = 1'b1; lat = MULT_LAT; end
      3'd2, 3'd3: begin accept = 1'b1; lat = DIV_LAT;  end
`ifdef MD_SEQUENCER_MADD_EN
      3'd6, 3'd7: begin accept = 1'b1; lat = MULT_LAT; end
`endif
      default: ;
    endcase
  end

  // Result datapath works only from the latched operands.
  always_comb begin
    a_s    = {{32{a_q[31]}}, a_q};
    b_s    = {{32{b_q[31]}}, b_q};
    prod_s = a_s * b_s;
    prod_u = {32'b0, a_q} * {32'b0, b_q};
    uq     = a_q / b_q;
    ur     = a_q % b_q;
    // 0x80000000 / -1 overflows a 32-bit signed divide; negation wraps to the required answer.
    if (b_q == 32'hFFFF_FFFF) begin
      sq = 32'd0 - a_q;
      sr = 32'd0;
    end else begin
      sq = 32'($signed(a_q) / $signed(b_q));
      sr = 32'($signed(a_q) % $signed(b_q));
    end
    commit_en = 1'b0;
    res_hi    = hi;
    res_lo    = lo;
    case (op_q)
      3'd0: begin commit_en = 1'b1; {res_hi, res_lo} = prod_s; end
      3'd1: begin commit_en = 1'b1; {res_hi, res_lo} = prod_u; end
      3'd2: begin commit_en = (b_q != 32'd0); res_hi = sr; res_lo = sq; end
      3'd3: begin commit_en = (b_q != 32'd0); res_hi = ur; res_lo = uq; end
`ifdef MD_SEQUENCER_MADD_EN
      3'd6: begin commit_en = 1'b1; {res_hi, res_lo} = {hi, lo} + prod_s; end
      3'd7: begin commit_en = 1'b1; {res_hi, res_lo} = {hi, lo} + prod_u; end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (op == 3'd4) hi <= a;
            else if (op == 3'd5) lo <= a;
            else if (accept) begin
              op_q  <= op;
              a_q   <= a;
              b_q   <= b;
              cnt   <= lat;
              busy  <= 1'b1;
              state <= RUN;
            end
          end
        end
        RUN: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            if (commit_en) begin
              hi <= res_hi;
              lo <= res_lo;
            end
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_md_sequencer.sv
// Bench for md_sequencer: deadline-based reference model checked every cycle,
// plus directed vectors with hand-computed HI/LO values.
module tb_md_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = '0;
  logic [31:0] a = '0, b = '0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;
  int bcnt = 0;
  int dcnt = 0;
  bit armed = 1'b0;

`ifdef MD_SEQUENCER_MADD_EN
  localparam bit MADD = 1'b1;
`else
  localparam bit MADD = 1'b0;
`endif

  md_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference arithmetic: returns the new {hi,lo}; unchanged on divide by zero.
  function automatic logic [63:0] model_result(input logic [2:0] o, input logic [31:0] x,
                                               input logic [31:0] y, input logic [31:0] h,
                                               input logic [31:0] l);
    int xi, yi;
    longint sx, sy;
    longint unsigned ux, uy;
    xi = x; yi = y; sx = xi; sy = yi; ux = {32'b0, x}; uy = {32'b0, y};
    case (o)
      3'd0: return 64'(sx * sy);
      3'd1: return ux * uy;
      3'd2: return (y == 0) ? {h, l} : {32'(sx % sy), 32'(sx / sy)};
      3'd3: return (y == 0) ? {h, l} : {32'(ux % uy), 32'(ux / uy)};
      3'd6: return {h, l} + 64'(sx * sy);
      3'd7: return {h, l} + ux * uy;
      default: return {h, l};
    endcase
  endfunction

  // Model: an accepted op commits on the edge exactly N edges after acceptance.
  logic        m_run = 1'b0, m_done = 1'b0;
  longint      m_edge = 0, m_commit = 0;
  logic [2:0]  m_op = '0;
  logic [31:0] m_a = '0, m_b = '0, m_hi = '0, m_lo = '0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_run <= 1'b0; m_done <= 1'b0; m_hi <= '0; m_lo <= '0;
      m_op <= '0; m_a <= '0; m_b <= '0;
    end else begin
      m_done <= 1'b0;
      m_edge <= m_edge + 1;
      if (m_run) begin
        if (m_edge == m_commit) begin
          {m_hi, m_lo} <= model_result(m_op, m_a, m_b, m_hi, m_lo);
          m_run  <= 1'b0;
          m_done <= 1'b1;
        end
      end else if (start) begin
        if (op == 3'd4) m_hi <= a;
        else if (op == 3'd5) m_lo <= a;
        else if (op < 3'd4 || MADD) begin
          m_run <= 1'b1; m_op <= op; m_a <= a; m_b <= b;
          m_commit <= m_edge + ((op == 3'd2 || op == 3'd3) ? 10 : 5);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (busy) bcnt++;
    if (done) dcnt++;
    if (armed) begin
      chk("cyc_busy", {31'b0, busy}, {31'b0, m_run});
      chk("cyc_done", {31'b0, done}, {31'b0, m_done});
      chk("cyc_hi", hi, m_hi);
      chk("cyc_lo", lo, m_lo);
    end
  end

  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s_timeout: got no done expected done within 40 cycles", name);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    reset = 1'b1;
    armed = 1'b1;

    // mult -2 * 3
    bcnt = 0; dcnt = 0;
    issue(3'd0, 32'hFFFF_FFFE, 32'd3);
    wait_done("mult");
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFFA);
    chk("mult_busy_cycles", bcnt, 32'd5);
    @(negedge clk);
    chk("mult_done_pulses", dcnt, 32'd1);
    chk("mult_done_low", {31'b0, done}, 32'd0);

    // multu max * max
    issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done("multu");
    chk("multu_hi", hi, 32'hFFFF_FFFE);
    chk("multu_lo", lo, 32'h0000_0001);

    // div -7 / 2
    bcnt = 0;
    issue(3'd2, 32'hFFFF_FFF9, 32'd2);
    wait_done("div");
    chk("div_lo", lo, 32'hFFFF_FFFD);
    chk("div_hi", hi, 32'hFFFF_FFFF);
    chk("div_busy_cycles", bcnt, 32'd10);

    // mthi then divu by zero
    bcnt = 0;
    issue(3'd4, 32'h1234_5678, 32'd0);
    chk("mthi_hi", hi, 32'h1234_5678);
    @(negedge clk);
    chk("mthi_no_busy", bcnt, 32'd0);
    issue(3'd3, 32'd5, 32'd0);
    wait_done("divu0");
    chk("divu0_hi", hi, 32'h1234_5678);
    chk("divu0_lo", lo, 32'hFFFF_FFFD);
    chk("divu0_busy_cycles", bcnt, 32'd10);

    // div 100 / 7 with a stray mtlo while busy
    issue(3'd2, 32'd100, 32'd7);
    repeat (2) @(negedge clk);
    start = 1'b1; op = 3'd5; a = 32'h0000_DEAD;
    @(negedge clk);
    start = 1'b0;
    wait_done("div_ign");
    chk("div_ign_lo", lo, 32'd14);
    chk("div_ign_hi", hi, 32'd2);

    // signed overflow case
    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done("div_ovf");
    chk("div_ovf_lo", lo, 32'h8000_0000);
    chk("div_ovf_hi", hi, 32'd0);

    // reset mid-run aborts the operation
    issue(3'd4, 32'd5, 32'd0);
    issue(3'd0, 32'd7, 32'd9);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_done", {31'b0, done}, 32'd0);
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);
    @(negedge clk);
    #2 reset = 1'b1;
    dcnt = 0;
    repeat (20) @(negedge clk);
    chk("abort_no_done", dcnt, 32'd0);

    // maddu accumulate, or ignored when the feature is absent
    issue(3'd4, 32'd0, 32'd0);
    issue(3'd5, 32'hFFFF_FFFF, 32'd0);
    bcnt = 0;
    issue(3'd7, 32'd1, 32'd1);
`ifdef MD_SEQUENCER_MADD_EN
    wait_done("maddu");
    chk("maddu_hi", hi, 32'd1);
    chk("maddu_lo", lo, 32'd0);
    chk("maddu_busy_cycles", bcnt, 32'd5);
`else
    repeat (6) @(negedge clk);
    chk("maddu_off_busy", bcnt, 32'd0);
    chk("maddu_off_hi", hi, 32'd0);
    chk("maddu_off_lo", lo, 32'hFFFF_FFFF);
`endif

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
